// File: rtl/access_pkg.sv
// Shared definitions for the parking access controller.
// The controller states are used by the RTL and the bench.
package access_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        ESPERA_CLAVE = 2'd1,
        ABIERTO      = 2'd2,
        BLOQUEO      = 2'd3
    } estado_t;

endpackage

// File: rtl/access_timer.sv
// Gate-open timeout: loads CICLOS-1 on clear, counts down while enabled.
// expira pulses during the enabled cycle in which the count is zero.
module access_timer #(
    parameter int unsigned CICLOS = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expira
);

    localparam int W = (CICLOS > 2) ? $clog2(CICLOS) : 1;

    logic [W-1:0] cuenta;

    always_ff @(posedge clock) begin
        if (reset) begin
            cuenta <= '0;
        end else if (clear) begin
            cuenta <= W'(CICLOS - 1);
        end else if (enable && cuenta != '0) begin
            cuenta <= cuenta - 1'b1;
        end
    end

    assign expira = enable && (cuenta == '0);

endmodule

// File: rtl/access_param.sv
// Parametrised single-lane parking access controller (Moore outputs).
// Define PARQUEO_CONTEO_EN to add the occupancy counter and full flag.
module access_param
    import access_pkg::*;
#(
    parameter int unsigned              CLAVE_WIDTH    = 16,
    parameter logic [CLAVE_WIDTH-1:0]   CLAVE_CORRECTA = 16'h1234,
    parameter int unsigned              MAX_INTENTOS   = 3,
    parameter int unsigned              TIMEOUT_CICLOS = 1024,
    parameter int unsigned              CAPACIDAD      = 32
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              sensor_llegada_vehiculo,
    input  logic                              sensor_ingreso_vehiculo,
    input  logic [CLAVE_WIDTH-1:0]            clave_ingresada,
    input  logic                              clave_valida,
`ifdef PARQUEO_CONTEO_EN
    input  logic                              sensor_salida_vehiculo,
    output logic                              parqueo_lleno,
`endif
    output logic                              senal_compuerta,
    output logic                              senal_alarma_pin,
    output logic                              senal_alarma_bloqueo,
    output logic [$clog2(MAX_INTENTOS+1)-1:0] intentos_fallidos
);

    localparam int IW = $clog2(MAX_INTENTOS + 1);
    localparam logic [IW-1:0] MAX_I = IW'(MAX_INTENTOS);

    estado_t       estado, estado_sig;
    logic          visto, visto_sig;
    logic [IW-1:0] intentos_sig;
    logic          pin_sig;
    logic          completo;
    logic          expira;
    logic          lleno;
    logic          clave_ok, clave_mal;

    assign clave_ok  = clave_valida && (clave_ingresada == CLAVE_CORRECTA);
    assign clave_mal = clave_valida && (clave_ingresada != CLAVE_CORRECTA);

    access_timer #(
        .CICLOS (TIMEOUT_CICLOS)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .clear  (estado != ABIERTO),
        .enable (estado == ABIERTO),
        .expira (expira)
    );

    always_comb begin
        estado_sig   = estado;
        visto_sig    = visto;
        intentos_sig = intentos_fallidos;
        pin_sig      = senal_alarma_pin;
        completo     = 1'b0;
        unique case (estado)
            IDLE: begin
                visto_sig = 1'b0;
                if (sensor_llegada_vehiculo) estado_sig = ESPERA_CLAVE;
            end
            ESPERA_CLAVE: begin
                visto_sig = 1'b0;
                if (clave_ok) begin
                    // A full lot leaves the driver waiting; not a wrong key.
                    if (!lleno) begin
                        estado_sig   = ABIERTO;
                        intentos_sig = '0;
                        pin_sig      = 1'b0;
                    end
                end else if (clave_mal) begin
                    if (intentos_fallidos != MAX_I)
                        intentos_sig = intentos_fallidos + 1'b1;
                    pin_sig = (intentos_sig == MAX_I);
                end else if (!sensor_llegada_vehiculo) begin
                    estado_sig = IDLE;
                end
            end
            ABIERTO: begin
                if (sensor_llegada_vehiculo && sensor_ingreso_vehiculo) begin
                    estado_sig = BLOQUEO;
                end else if (visto && !sensor_ingreso_vehiculo
                             && !sensor_llegada_vehiculo) begin
                    estado_sig = IDLE;
                    completo   = 1'b1;
                end else if (sensor_ingreso_vehiculo) begin
                    visto_sig = 1'b1;
                end else if (!visto && expira) begin
                    estado_sig = IDLE;
                end
            end
            BLOQUEO: begin
                if (clave_ok) estado_sig = IDLE;
            end
            default: estado_sig = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado               <= IDLE;
            visto                <= 1'b0;
            intentos_fallidos    <= '0;
            senal_alarma_pin     <= 1'b0;
            senal_compuerta      <= 1'b0;
            senal_alarma_bloqueo <= 1'b0;
        end else begin
            estado               <= estado_sig;
            visto                <= visto_sig;
            intentos_fallidos    <= intentos_sig;
            senal_alarma_pin     <= pin_sig;
            senal_compuerta      <= (estado_sig == ABIERTO);
            senal_alarma_bloqueo <= (estado_sig == BLOQUEO);
        end
    end

`ifdef PARQUEO_CONTEO_EN
    localparam int OW = $clog2(CAPACIDAD + 1);
    localparam logic [OW-1:0] CAP = OW'(CAPACIDAD);

    logic [OW-1:0] ocupacion, ocup_sig;

    always_comb begin
        ocup_sig = ocupacion;
        if (completo && !sensor_salida_vehiculo) begin
            if (ocupacion != CAP) ocup_sig = ocupacion + 1'b1;
        end else if (!completo && sensor_salida_vehiculo) begin
            if (ocupacion != '0) ocup_sig = ocupacion - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ocupacion     <= '0;
            parqueo_lleno <= 1'b0;
        end else begin
            ocupacion     <= ocup_sig;
            parqueo_lleno <= (ocup_sig == CAP);
        end
    end

    assign lleno = parqueo_lleno;
`else
    assign lleno = 1'b0;
`endif

endmodule

// File: tb/tb_access_param.sv
// Randomised and directed bench for access_param against a cycle model.
// Build with PARQUEO_CONTEO_EN defined to also exercise occupancy.
module tb_access_param;
    import access_pkg::*;

    localparam logic [15:0] KEY = 16'h1234;
    localparam int MAXI = 3;
    localparam int TMO  = 16;
    localparam int CAP  = 2;
`ifdef PARQUEO_CONTEO_EN
    localparam bit CONTEO = 1'b1;
`else
    localparam bit CONTEO = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        llegada, ingreso, strobe, salida;
    logic [15:0] clave;
    logic        gate, pin, bloq, lleno;
    logic [1:0]  intentos;

    int n_total = 0;
    int n_bad   = 0;

    estado_t m_mode;
    int      m_fails, m_open, m_occ;
    bit      m_seen;

    always #5 clock = ~clock;

    access_param #(
        .CLAVE_WIDTH    (16),
        .CLAVE_CORRECTA (KEY),
        .MAX_INTENTOS   (MAXI),
        .TIMEOUT_CICLOS (TMO),
        .CAPACIDAD      (CAP)
    ) dut (
        .clock                   (clock),
        .reset                   (reset),
        .sensor_llegada_vehiculo (llegada),
        .sensor_ingreso_vehiculo (ingreso),
        .clave_ingresada         (clave),
        .clave_valida            (strobe),
`ifdef PARQUEO_CONTEO_EN
        .sensor_salida_vehiculo  (salida),
        .parqueo_lleno           (lleno),
`endif
        .senal_compuerta         (gate),
        .senal_alarma_pin        (pin),
        .senal_alarma_bloqueo    (bloq),
        .intentos_fallidos       (intentos)
    );

`ifndef PARQUEO_CONTEO_EN
    assign lleno = 1'b0;
`endif

    task automatic chk(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_full();
        return CONTEO && (m_occ == CAP);
    endfunction

    // Reference: time spent open is tracked as an elapsed-cycle count.
    task automatic model_step();
        bit good;
        good = strobe && (clave == KEY);
        if (reset) begin
            m_mode = IDLE; m_fails = 0; m_open = 0; m_seen = 0; m_occ = 0;
            return;
        end
        case (m_mode)
            IDLE:
                if (llegada) m_mode = ESPERA_CLAVE;
            ESPERA_CLAVE:
                if (good) begin
                    if (!m_full()) begin
                        m_mode = ABIERTO; m_fails = 0;
                        m_open = 0; m_seen = 0;
                    end
                end else if (strobe) begin
                    m_fails = (m_fails + 1 > MAXI) ? MAXI : m_fails + 1;
                end else if (!llegada) begin
                    m_mode = IDLE;
                end
            ABIERTO: begin
                if (llegada && ingreso) begin
                    m_mode = BLOQUEO;
                end else if (m_seen && !ingreso && !llegada) begin
                    m_mode = IDLE;
                    if (!(CONTEO && salida) && m_occ < CAP) m_occ++;
                    salida = 1'b0;
                end else if (ingreso) begin
                    m_seen = 1;
                end else if (!m_seen && m_open == TMO - 1) begin
                    m_mode = IDLE;
                end
                m_open++;
            end
            BLOQUEO:
                if (good) m_mode = IDLE;
            default: m_mode = IDLE;
        endcase
        if (CONTEO && salida && m_occ > 0) m_occ--;
    endtask

    task automatic tick(input logic rst, input logic lleg, input logic ing,
                        input logic [15:0] k, input logic stb, input logic sal);
        logic sal_m;
        reset = rst; llegada = lleg; ingreso = ing;
        clave = k; strobe = stb; salida = sal;
        @(posedge clock);
        sal_m = salida;
        model_step();
        salida = sal_m;
        #1;
        chk("gate", int'(gate), int'(m_mode == ABIERTO));
        chk("pin", int'(pin), int'(m_fails == MAXI));
        chk("bloqueo", int'(bloq), int'(m_mode == BLOQUEO));
        chk("intentos", int'(intentos), m_fails);
        if (CONTEO) chk("lleno", int'(lleno), int'(m_occ == CAP));
    endtask

    initial begin
        int hi;
        reset = 1'b1; llegada = 0; ingreso = 0;
        clave = '0; strobe = 0; salida = 0;
        m_mode = IDLE; m_fails = 0; m_open = 0; m_seen = 0; m_occ = 0;

        tick(1, 0, 0, 0, 0, 0);
        chk("rst_gate", int'(gate), 0);
        chk("rst_intentos", int'(intentos), 0);

        // 1: normal entry
        tick(0, 1, 0, 16'h0, 0, 0);
        tick(0, 1, 0, KEY, 1, 0);
        chk("t1_open", int'(gate), 1);
        tick(0, 0, 1, 16'h0, 0, 0);
        tick(0, 0, 0, 16'h0, 0, 0);
        chk("t1_close", int'(gate), 0);

        // 2: wrong keys then right key
        tick(0, 1, 0, 16'h0, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            tick(0, 1, 0, 16'h0000, 1, 0);
            chk("t2_cnt", int'(intentos), i);
        end
        chk("t2_pin", int'(pin), 1);
        tick(0, 1, 0, KEY, 1, 0);
        chk("t2_pin_clr", int'(pin), 0);
        chk("t2_gate", int'(gate), 1);

        // 3: tailgating lock-out
        tick(0, 1, 1, 16'h0, 0, 0);
        chk("t3_bloq", int'(bloq), 1);
        chk("t3_gate", int'(gate), 0);
        tick(0, 0, 0, 16'h5555, 1, 0);
        chk("t3_wrong", int'(bloq), 1);
        chk("t3_nocount", int'(intentos), 0);
        tick(0, 0, 0, KEY, 1, 0);
        chk("t3_release", int'(bloq), 0);

        // 4: timeout
        tick(0, 1, 0, 16'h0, 0, 0);
        hi = 0;
        tick(0, 1, 0, KEY, 1, 0);
        hi += int'(gate);
        for (int i = 0; i < 20; i++) begin
            tick(0, 0, 0, 16'h0, 0, 0);
            hi += int'(gate);
        end
        chk("t4_open_cycles", hi, TMO);

        // 5: reset while open, and reset with pending attempts
        tick(0, 1, 0, 16'h0, 0, 0);
        tick(0, 1, 0, 16'h1, 1, 0);
        tick(0, 1, 0, 16'h2, 1, 0);
        chk("t5_two", int'(intentos), 2);
        tick(1, 1, 0, 16'h0, 0, 0);
        chk("t5_rst_cnt", int'(intentos), 0);
        tick(0, 1, 0, 16'h0, 0, 0);
        tick(0, 1, 0, KEY, 1, 0);
        tick(1, 1, 1, KEY, 1, 0);
        chk("t5_rst_gate", int'(gate), 0);

`ifdef PARQUEO_CONTEO_EN
        // 6: lot fills up
        for (int n = 0; n < 2; n++) begin
            tick(0, 1, 0, 16'h0, 0, 0);
            tick(0, 1, 0, KEY, 1, 0);
            tick(0, 0, 1, 16'h0, 0, 0);
            tick(0, 0, 0, 16'h0, 0, 0);
        end
        chk("t6_full", int'(lleno), 1);
        tick(0, 1, 0, 16'h0, 0, 0);
        tick(0, 1, 0, KEY, 1, 0);
        chk("t6_shut", int'(gate), 0);
        chk("t6_notwrong", int'(intentos), 0);
        tick(0, 0, 0, 16'h0, 0, 1);
        chk("t6_free", int'(lleno), 0);
`endif

        // random traffic
        for (int i = 0; i < 4000; i++) begin
            logic [15:0] k;
            k = ($urandom_range(0, 1) == 0) ? KEY : 16'($urandom);
            tick($urandom_range(0, 199) == 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 3) == 0,
                 k,
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 9) == 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
